// File: rtl/number_tester_pkg.sv
// Shared parameters, state encoding and helpers for the BBS word quality tester.
package number_tester_pkg;

  localparam int unsigned SIZE        = 256;
  localparam int unsigned ONES_MIN    = 108;
  localparam int unsigned ONES_MAX    = 148;
  localparam int unsigned RUNS_MIN    = 108;
  localparam int unsigned RUNS_MAX    = 148;
  localparam int unsigned LONGEST_MAX = 16;

  localparam int unsigned CW    = $clog2(SIZE + 1);
  localparam int unsigned IDX_W = $clog2(SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    JUDGE = 2'd2
  } state_t;

  // Inclusive range test on a CW-bit statistic.
  function automatic logic in_range(input logic [CW-1:0] v,
                                    input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/number_tester.sv
// Captures a SIZE-bit word on start, scans it MSB first and judges
// monobit, runs and longest-run statistics against fixed bounds.
module number_tester
  import number_tester_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] number,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   ones_cnt,
  output logic [CW-1:0]   runs_cnt,
  output logic [CW-1:0]   longest_run
);

  state_t            state;
  state_t            state_nx;
  logic [SIZE-1:0]   shreg;
  logic [IDX_W-1:0]  idx;
  logic [CW-1:0]     run_len;
  logic              prev;

  logic              bit_c;
  logic              first_c;
  logic              new_run_c;
  logic [CW-1:0]     run_len_nx_c;
  logic [CW-1:0]     runs_nx_c;
  logic [CW-1:0]     longest_nx_c;
  logic              pass_c;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (idx == IDX_W'(SIZE - 1)) state_nx = JUDGE;
      JUDGE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-bit statistic updates for the bit currently at the MSB.
  always_comb begin
    bit_c        = shreg[SIZE-1];
    first_c      = (idx == '0);
    new_run_c    = first_c || (bit_c != prev);
    run_len_nx_c = new_run_c ? CW'(1) : run_len + CW'(1);
    runs_nx_c    = first_c ? CW'(1) : ((bit_c != prev) ? runs_cnt + CW'(1) : runs_cnt);
    longest_nx_c = (run_len_nx_c > longest_run) ? run_len_nx_c : longest_run;
    pass_c       = in_range(ones_cnt, CW'(ONES_MIN), CW'(ONES_MAX)) &&
                   in_range(runs_cnt, CW'(RUNS_MIN), CW'(RUNS_MAX)) &&
                   (longest_run <= CW'(LONGEST_MAX));
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      idx         <= '0;
      run_len     <= '0;
      prev        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      ones_cnt    <= '0;
      runs_cnt    <= '0;
      longest_run <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg       <= number;
            idx         <= '0;
            run_len     <= '0;
            prev        <= 1'b0;
            busy        <= 1'b1;
            pass        <= 1'b0;
            ones_cnt    <= '0;
            runs_cnt    <= '0;
            longest_run <= '0;
          end
        end
        SCAN: begin
          shreg       <= {shreg[SIZE-2:0], 1'b0};
          idx         <= idx + IDX_W'(1);
          ones_cnt    <= ones_cnt + CW'(bit_c);
          runs_cnt    <= runs_nx_c;
          run_len     <= run_len_nx_c;
          longest_run <= longest_nx_c;
          prev        <= bit_c;
        end
        JUDGE: begin
          pass <= pass_c;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_number_tester.sv
// Self-checking bench for number_tester: directed and random words against
// a loop-based statistics model.
module tb_number_tester;

  logic         clk;
  logic         reset;
  logic         start;
  logic [255:0] number;
  logic         busy;
  logic         done;
  logic         pass;
  logic [8:0]   ones_cnt;
  logic [8:0]   runs_cnt;
  logic [8:0]   longest_run;

  int errors = 0;
  int checks = 0;

  number_tester dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .number      (number),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .ones_cnt    (ones_cnt),
    .runs_cnt    (runs_cnt),
    .longest_run (longest_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Statistics straight from the definitions: count ones, count bit changes.
  function automatic void model(input logic [255:0] w, output int ones,
                                output int runs, output int longest, output int ok);
    int cur;
    ones = 0; runs = 1; longest = 1; cur = 1;
    for (int i = 255; i >= 0; i--) begin
      if (w[i]) ones++;
      if (i < 255) begin
        if (w[i] != w[i+1]) begin runs++; cur = 1; end
        else cur++;
        if (cur > longest) longest = cur;
      end
    end
    ok = (ones >= 108 && ones <= 148 && runs >= 108 && runs <= 148 && longest <= 16) ? 1 : 0;
  endfunction

  task automatic check_results(input string tag, input logic [255:0] w);
    int o, r, l, p;
    model(w, o, r, l, p);
    check({tag, "_ones"}, int'(ones_cnt), o);
    check({tag, "_runs"}, int'(runs_cnt), r);
    check({tag, "_longest"}, int'(longest_run), l);
    check({tag, "_pass"}, int'(pass), p);
  endtask

  // Pulse start with word w, wait for done, check timing and results.
  task automatic run_word(input string tag, input logic [255:0] w);
    int k;
    bit seen;
    @(negedge clk);
    start = 1'b1; number = w;
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    number = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    seen = 0; k = 0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1; k = i; end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_latency"}, k, 257);
    check({tag, "_busy_done"}, int'(busy), 0);
    check_results(tag, w);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    check_results({tag, "_held"}, w);
  endtask

  logic [255:0] w_a, w_b, w_c, r1, r2;
  int done_count;

  initial begin
    reset = 1'b0; start = 1'b0; number = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_ones", int'(ones_cnt), 0);
    check("rst_runs", int'(runs_cnt), 0);
    check("rst_longest", int'(longest_run), 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    // Directed words from the boundary cases.
    run_word("zero", 256'd0);
    check("zero_lit_longest", int'(longest_run), 256);
    w_a = {64{4'hA}};
    run_word("a5", w_a);
    check("a5_lit_runs", int'(runs_cnt), 256);
    w_c = {64{4'hC}};
    run_word("cc", w_c);
    check("cc_lit_pass", int'(pass), 1);
    w_b = 256'd1 << 255;
    run_word("msb", w_b);
    check("msb_lit_longest", int'(longest_run), 255);
    run_word("ones", ~256'd0);

    // Random words: unbiased, sparse and dense.
    for (int n = 0; n < 8; n++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      case (n % 4)
        0, 1: run_word("rnd", r1);
        2:    run_word("rnd_and", r1 & r2);
        default: run_word("rnd_or", r1 | r2);
      endcase
    end
    // Random word with a forced long run of zeros.
    r1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r1[100 +: 20] = '0;
    run_word("rnd_run", r1);

    // Start back-to-back in the done cycle must be accepted.
    @(negedge clk); start = 1'b1; number = w_c;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin @(posedge clk); #1; end
    @(negedge clk); start = 1'b1; number = w_a;
    @(posedge clk); #1;
    check("b2b_busy", int'(busy), 1);
    check("b2b_done_clear", int'(done), 0);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin @(posedge clk); #1; end
    check_results("b2b", w_a);

    // Second start during a scan is ignored.
    r1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk); start = 1'b1; number = r1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    done_count = 0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      if (done) done_count++;
      if (i == 10) begin
        @(negedge clk); start = 1'b1; number = w_c;
        @(negedge clk); start = 1'b0;
      end
      if (i == 257) check_results("ignore", r1);
    end
    check("ignore_done_count", done_count, 1);
    check("ignore_busy", int'(busy), 0);
    check_results("ignore_final", r1);

    // Reset mid-scan aborts with no done pulse.
    @(negedge clk); start = 1'b1; number = w_b;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    done_count = 0;
    repeat (100) begin @(posedge clk); #1; if (done) done_count++; end
    @(negedge clk); reset = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ones", int'(ones_cnt), 0);
    check("rst_mid_runs", int'(runs_cnt), 0);
    check("rst_mid_longest", int'(longest_run), 0);
    check("rst_mid_pass", int'(pass), 0);
    repeat (5) begin @(posedge clk); #1; if (done) done_count++; end
    check("rst_mid_no_done", done_count, 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done) done_count++; end
    check("rst_rel_no_done", done_count, 0);
    run_word("after_rst", w_c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
